// File: rtl/blake2s_msg_ctrl.sv
// rtl/blake2s_msg_ctrl.sv - byte-stream to BLAKE2s core sequencer with block packing and digest handshake
module blake2s_msg_ctrl #(
  parameter int BLOCK_BYTES = 64,
  parameter int LEN_W       = 64,
  parameter int DIGEST_BITS = 88
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     in_valid_i,
  input  logic [7:0]               in_data_i,
  input  logic                     in_last_i,
  input  logic                     in_empty_i,
  output logic                     in_ready_o,
  output logic                     core_init_o,
  output logic                     core_next_o,
  output logic                     core_final_o,
  output logic [8*BLOCK_BYTES-1:0] core_block_o,
  output logic [LEN_W-1:0]         core_length_o,
  input  logic                     core_ready_i,
  input  logic [DIGEST_BITS-1:0]   core_digest_i,
  input  logic                     core_dvalid_i,
  output logic [DIGEST_BITS-1:0]   digest_o,
  output logic                     digest_valid_o,
  input  logic                     digest_ready_i,
  output logic                     busy_o
);

  localparam int ADDR_W = $clog2(BLOCK_BYTES);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(BLOCK_BYTES);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_FILL  = 3'd2,
    S_NEXT  = 3'd3,
    S_WAITN = 3'd4,
    S_FINAL = 3'd5,
    S_WAITF = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t                   state_q;
  logic [8*BLOCK_BYTES-1:0] blk_q;
  logic [PTR_W-1:0]         ptr_q;
  logic [LEN_W-1:0]         cnt_q;
  logic [LEN_W-1:0]         core_length_q;
  logic                     empty_q;
  logic                     core_init_q;
  logic                     core_next_q;
  logic                     core_final_q;
  logic [DIGEST_BITS-1:0]   digest_q;
  logic                     digest_valid_q;

  // Any command pulse currently on the core interface; used to keep pulses apart.
  logic                     pulse_q;
  logic [ADDR_W+2:0]        bit_idx;

  assign pulse_q = core_init_q | core_next_q | core_final_q;
  assign bit_idx = {ptr_q[ADDR_W-1:0], 3'b000};

  assign in_ready_o     = (state_q == S_FILL) && (ptr_q != PTR_FULL);
  assign core_init_o    = core_init_q;
  assign core_next_o    = core_next_q;
  assign core_final_o   = core_final_q;
  assign core_block_o   = blk_q;
  assign core_length_o  = core_length_q;
  assign digest_o       = digest_q;
  assign digest_valid_o = digest_valid_q;
  assign busy_o         = (state_q != S_IDLE);

  // Message sequencer: packs bytes, issues init/next/final, captures and hands off the digest.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      blk_q          <= '0;
      ptr_q          <= '0;
      cnt_q          <= '0;
      core_length_q  <= '0;
      empty_q        <= 1'b0;
      core_init_q    <= 1'b0;
      core_next_q    <= 1'b0;
      core_final_q   <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      core_init_q  <= 1'b0;
      core_next_q  <= 1'b0;
      core_final_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            blk_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            empty_q <= in_empty_i;
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          if (core_ready_i && !pulse_q) begin
            core_init_q <= 1'b1;
            state_q     <= empty_q ? S_FINAL : S_FILL;
          end
        end
        S_FILL: begin
          if (in_valid_i) begin
            if (ptr_q != PTR_FULL) begin
              blk_q[bit_idx +: 8] <= in_data_i;
              ptr_q               <= ptr_q + PTR_ONE;
              cnt_q               <= cnt_q + CNT_ONE;
              if (in_last_i) begin
                state_q <= S_FINAL;
              end
            end else begin
              // Full block and more data pending: this block is not the last one.
              state_q <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (core_ready_i && !pulse_q) begin
            core_next_q   <= 1'b1;
            core_length_q <= cnt_q;
            state_q       <= S_WAITN;
          end
        end
        S_WAITN: begin
          // Ready is ignored during the pulse cycle itself, so a core that drops ready
          // late or never drops it still gets at least one cycle before the buffer clears.
          if (core_ready_i && !core_next_q) begin
            blk_q   <= '0;
            ptr_q   <= '0;
            state_q <= S_FILL;
          end
        end
        S_FINAL: begin
          if (core_ready_i && !pulse_q) begin
            core_final_q  <= 1'b1;
            core_length_q <= cnt_q;
            state_q       <= S_WAITF;
          end
        end
        S_WAITF: begin
          if (core_dvalid_i) begin
            digest_q       <= core_digest_i;
            digest_valid_q <= 1'b1;
            state_q        <= S_DONE;
          end
        end
        S_DONE: begin
          if (digest_ready_i) begin
            digest_valid_q <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blake2s_msg_ctrl.sv
// tb/tb_blake2s_msg_ctrl.sv - scoreboard bench for blake2s_msg_ctrl with a behavioural core model
module tb_blake2s_msg_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         in_empty = 1'b0;
  logic         digest_ready = 1'b0;
  logic         in_ready;
  logic         core_init;
  logic         core_next;
  logic         core_final;
  logic [511:0] core_block;
  logic [63:0]  core_length;
  logic         core_ready;
  logic [87:0]  core_digest = '0;
  logic         core_dvalid = 1'b0;
  logic [87:0]  digest;
  logic         digest_valid;
  logic         busy;

  always #5 clk = ~clk;

  blake2s_msg_ctrl #(
    .BLOCK_BYTES(64),
    .LEN_W(64),
    .DIGEST_BITS(88)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .in_valid_i     (in_valid),
    .in_data_i      (in_data),
    .in_last_i      (in_last),
    .in_empty_i     (in_empty),
    .in_ready_o     (in_ready),
    .core_init_o    (core_init),
    .core_next_o    (core_next),
    .core_final_o   (core_final),
    .core_block_o   (core_block),
    .core_length_o  (core_length),
    .core_ready_i   (core_ready),
    .core_digest_i  (core_digest),
    .core_dvalid_i  (core_dvalid),
    .digest_o       (digest),
    .digest_valid_o (digest_valid),
    .digest_ready_i (digest_ready),
    .busy_o         (busy)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    int           kind;
    logic [63:0]  len;
    logic [511:0] blk;
  } exp_t;

  exp_t         sb_q[$];
  logic [87:0]  dig_q[$];
  int           n_init = 0;
  int           n_next = 0;
  int           n_final = 0;
  logic [511:0] last_fin_blk = '0;

  function automatic logic [87:0] fake_digest(input logic [511:0] blk, input logic [63:0] len);
    logic [87:0] acc;
    acc = {24'hA5C31E, len};
    for (int i = 0; i < 64; i++) begin
      acc = {acc[86:0], acc[87]} ^ {80'h0, blk[8*i +: 8]} ^ 88'(i);
    end
    return acc;
  endfunction

  logic        model_ready = 1'b1;
  logic        stall = 1'b0;
  int          lat = 3;
  int          busy_cnt = 0;
  bit          pend_final = 1'b0;
  logic [511:0] fin_blk = '0;
  logic [63:0]  fin_len = '0;

  assign core_ready = model_ready & ~stall;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      model_ready = 1'b1;
      busy_cnt    = 0;
      pend_final  = 1'b0;
      core_dvalid = 1'b0;
    end else begin
      core_dvalid = 1'b0;
      if (core_init || core_next || core_final) begin
        model_ready = 1'b0;
        busy_cnt    = lat;
        pend_final  = core_final;
        if (core_final) begin
          fin_blk = core_block;
          fin_len = core_length;
        end
      end else if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
        if (busy_cnt == 0) begin
          model_ready = 1'b1;
          if (pend_final) begin
            core_dvalid = 1'b1;
            core_digest = fake_digest(fin_blk, fin_len);
            pend_final  = 1'b0;
          end
        end
      end
    end
  end

  int   np;
  int   kind;
  bit   prev_pulse = 1'b0;
  exp_t e_mon;

  always @(negedge clk) begin
    if (!rst) begin
      np = int'(core_init) + int'(core_next) + int'(core_final);
      if (np != 0) begin
        total++;
        if (np != 1 || prev_pulse) begin
          bad++;
          $display("FAIL pulse_shape: pulses=%0d prev_cycle_pulse=%0d required pulses=1 prev=0", np, prev_pulse);
        end
        if (core_init) n_init++;
        if (core_next) n_next++;
        if (core_final) begin
          n_final++;
          last_fin_blk = core_block;
        end
        kind = core_init ? 0 : (core_next ? 1 : 2);
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: kind=%0d with empty scoreboard", kind);
        end else begin
          e_mon = sb_q.pop_front();
          if (kind !== e_mon.kind) begin
            bad++;
            $display("FAIL pulse_kind: got=%0d required=%0d", kind, e_mon.kind);
          end else if (kind != 0) begin
            total++;
            if (core_length !== e_mon.len) begin
              bad++;
              $display("FAIL core_length: got=%0d required=%0d", core_length, e_mon.len);
            end
            total++;
            if (core_block !== e_mon.blk) begin
              bad++;
              $display("FAIL core_block: got=%h required=%h", core_block, e_mon.blk);
            end
          end
        end
      end
      prev_pulse = (np != 0);
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic push_expect(input int n, input logic [7:0] base);
    exp_t e;
    int nblk;
    logic [511:0] blk;
    e.kind = 0;
    e.len  = '0;
    e.blk  = '0;
    sb_q.push_back(e);
    nblk = (n == 0) ? 1 : (n + 63) / 64;
    blk = '0;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) begin
        if (b * 64 + j < n) blk[8*j +: 8] = base + 8'(b * 64 + j);
      end
      e.kind = (b == nblk - 1) ? 2 : 1;
      e.len  = (b == nblk - 1) ? 64'(n) : 64'((b + 1) * 64);
      e.blk  = blk;
      sb_q.push_back(e);
    end
    dig_q.push_back(fake_digest(blk, 64'(n)));
  endtask

  task automatic start_msg(input bit empty);
    @(negedge clk);
    start    = 1'b1;
    in_empty = empty;
    @(negedge clk);
    start    = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready=%0d required=1 within 300 cycles", in_ready);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i), i == n - 1);
  endtask

  task automatic finish_msg(input int hold);
    int n;
    logic [87:0] exp_d;
    n = 0;
    digest_ready = 1'b0;
    while (!digest_valid) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        total++;
        bad++;
        $display("FAIL digest_timeout: digest_valid=%0d required=1 within 500 cycles", digest_valid);
        return;
      end
    end
    if (dig_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_digest: got=%h with empty scoreboard", digest);
      return;
    end
    exp_d = dig_q.pop_front();
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      total++;
      if (digest_valid !== 1'b1 || digest !== exp_d) begin
        bad++;
        $display("FAIL digest_hold: cycle=%0d valid=%0d digest=%h required valid=1 digest=%h", k, digest_valid, digest, exp_d);
      end
    end
    total++;
    if (digest !== exp_d) begin
      bad++;
      $display("FAIL digest_value: got=%h required=%h", digest, exp_d);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    total++;
    if (busy !== 1'b0 || digest_valid !== 1'b0) begin
      bad++;
      $display("FAIL after_handshake: busy=%0d digest_valid=%0d required 0 0", busy, digest_valid);
    end
  endtask

  task automatic check_counts(input string name, input int di, input int dn, input int df,
                              input int ei, input int en, input int ef);
    total++;
    if (di !== ei || dn !== en || df !== ef || sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_counts: init=%0d next=%0d final=%0d left=%0d required %0d %0d %0d 0",
               name, di, dn, df, sb_q.size(), ei, en, ef);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || core_init !== 1'b0 || core_next !== 1'b0 || core_final !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: busy=%0d in_ready=%0d init=%0d next=%0d final=%0d required all 0",
               busy, in_ready, core_init, core_next, core_final);
    end
    total++;
    if (core_length !== 64'h0 || core_block !== 512'h0 || digest !== 88'h0 || digest_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: length=%0d block_nz=%0d digest=%h dvalid=%0d required all 0",
               core_length, |core_block, digest, digest_valid);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: busy=%0d in_ready=%0d required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_abc();
    int i0, n0, f0;
    i0 = n_init; n0 = n_next; f0 = n_final;
    push_expect(3, 8'h61);
    start_msg(1'b0);
    send_msg(3, 8'h61);
    finish_msg(0);
    check_counts("abc", n_init - i0, n_next - n0, n_final - f0, 1, 0, 1);
    total++;
    if (last_fin_blk[23:0] !== 24'h636261 || last_fin_blk[511:24] !== '0) begin
      bad++;
      $display("FAIL abc_block: low=%h upper_nz=%0d required low=636261 upper 0", last_fin_blk[23:0], |last_fin_blk[511:24]);
    end
  endtask

  task automatic test_empty();
    int i0, n0, f0;
    i0 = n_init; n0 = n_next; f0 = n_final;
    push_expect(0, 8'h00);
    start_msg(1'b1);
    finish_msg(0);
    check_counts("empty", n_init - i0, n_next - n0, n_final - f0, 1, 0, 1);
  endtask

  task automatic test_exact_64();
    int i0, n0, f0;
    i0 = n_init; n0 = n_next; f0 = n_final;
    push_expect(64, 8'h00);
    start_msg(1'b0);
    send_msg(64, 8'h00);
    finish_msg(0);
    check_counts("exact64", n_init - i0, n_next - n0, n_final - f0, 1, 0, 1);
  endtask

  task automatic test_65();
    int i0, n0, f0;
    i0 = n_init; n0 = n_next; f0 = n_final;
    push_expect(65, 8'h00);
    start_msg(1'b0);
    send_msg(65, 8'h00);
    finish_msg(0);
    check_counts("len65", n_init - i0, n_next - n0, n_final - f0, 1, 1, 1);
    total++;
    if (last_fin_blk[7:0] !== 8'h40 || last_fin_blk[511:8] !== '0) begin
      bad++;
      $display("FAIL len65_block: low=%h upper_nz=%0d required low=40 upper 0", last_fin_blk[7:0], |last_fin_blk[511:8]);
    end
  endtask

  task automatic test_ready_stall();
    int i0, n0, f0;
    i0 = n_init; n0 = n_next; f0 = n_final;
    push_expect(65, 8'h10);
    start_msg(1'b0);
    for (int i = 0; i < 64; i++) send_byte(8'h10 + 8'(i), 1'b0);
    stall    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h50;
    in_last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || n_next != n0) begin
        bad++;
        $display("FAIL stall_hold: cycle=%0d in_ready=%0d nexts=%0d required 0 %0d", k, in_ready, n_next, n0);
      end
    end
    stall = 1'b0;
    send_byte(8'h50, 1'b1);
    finish_msg(0);
    check_counts("stall", n_init - i0, n_next - n0, n_final - f0, 1, 1, 1);
  endtask

  task automatic test_digest_hold();
    push_expect(7, 8'hE0);
    start_msg(1'b0);
    send_msg(7, 8'hE0);
    finish_msg(5);
  endtask

  task automatic test_back_to_back();
    int i0, n0, f0;
    i0 = n_init; n0 = n_next; f0 = n_final;
    push_expect(130, 8'h80);
    start_msg(1'b0);
    send_msg(130, 8'h80);
    finish_msg(0);
    push_expect(5, 8'hC0);
    start_msg(1'b0);
    send_msg(5, 8'hC0);
    finish_msg(0);
    check_counts("b2b", n_init - i0, n_next - n0, n_final - f0, 2, 2, 2);
  endtask

  task automatic test_reset_waitn();
    int n0, n;
    lat = 20;
    n0 = n_next;
    push_expect(65, 8'h20);
    start_msg(1'b0);
    for (int i = 0; i < 64; i++) send_byte(8'h20 + 8'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h60;
    in_last  = 1'b1;
    n = 0;
    while (n_next == n0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n_next == n0) begin
      bad++;
      $display("FAIL waitn_reach: nexts=%0d required %0d", n_next, n0 + 1);
    end
    rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || core_init !== 1'b0 || core_next !== 1'b0 || core_final !== 1'b0) begin
      bad++;
      $display("FAIL waitn_rst_ctrl: busy=%0d in_ready=%0d init=%0d next=%0d final=%0d required all 0",
               busy, in_ready, core_init, core_next, core_final);
    end
    total++;
    if (core_length !== 64'h0 || core_block !== 512'h0 || digest !== 88'h0 || digest_valid !== 1'b0) begin
      bad++;
      $display("FAIL waitn_rst_data: length=%0d block_nz=%0d digest=%h dvalid=%0d required all 0",
               core_length, |core_block, digest, digest_valid);
    end
    rst = 1'b0;
    sb_q.delete();
    dig_q.delete();
    lat = 3;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL waitn_rst_idle: busy=%0d required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_exact_64();
    test_65();
    test_ready_stall();
    test_digest_hold();
    test_back_to_back();
    test_reset_waitn();
    test_abc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
